out_channel_checker: RTL and testbench



---
 rtl/out_channel_checker_if.sv | 11 +
 rtl/out_channel_checker.sv | 114 +++++++++++
 tb/tb_out_channel_checker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_channel_checker_if.sv
// Out channel word stream from the executing program to the checker.
interface out_channel_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/out_channel_checker.sv
// Captures program out-channel words into a circular buffer, then checks it against an expected
// table one entry per cycle; finished rises NExpect+1 cycles after prog_done. in_ready is high only in RUN.
module out_channel_checker #(
  parameter  int W       = 12,
  parameter  int NOut    = 3,
  parameter  int NExpect = 3,
  localparam int AW      = (NOut > 1) ? $clog2(NOut) : 1,
  localparam int FW      = $clog2(NOut) + 1
) (
  input  logic          clock,
  input  logic          reset,
  out_channel_if.slave  in_ch,
  input  logic          prog_done,
  input  logic          exp_we,
  input  logic [AW-1:0] exp_addr,
  input  logic [W-1:0]  exp_data,
  output logic [15:0]   words_seen,
  output logic          wrapped,
  output logic [FW-1:0] fail_index,
  output logic          finished,
  output logic          success
);

  typedef enum logic [1:0] {RUN, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [AW-1:0] chk_idx_q, chk_idx_d;
  logic [15:0]   words_seen_q, words_seen_d;
  logic          wrapped_q, wrapped_d;
  logic [FW-1:0] fail_index_q, fail_index_d;
  logic          success_q, success_d;
  logic [W-1:0]  buf_q [NOut];
  logic [W-1:0]  buf_d [NOut];
  logic [W-1:0]  exp_q [NOut];
  logic [W-1:0]  exp_d [NOut];
  logic          fire;
  logic          mismatch;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    chk_idx_d    = chk_idx_q;
    words_seen_d = words_seen_q;
    wrapped_d    = wrapped_q;
    fail_index_d = fail_index_q;
    success_d    = success_q;
    buf_d        = buf_q;
    exp_d        = exp_q;
    in_ch.in_ready = (state_q == RUN);
    fire         = in_ch.in_valid && (state_q == RUN);
    mismatch     = (buf_q[chk_idx_q] != exp_q[chk_idx_q]);

    // The expected table is independent storage: writable alongside captures, frozen while checking.
    if (exp_we && (state_q != CHECK) && (32'(exp_addr) < NOut)) begin
      exp_d[exp_addr] = exp_data;
    end

    case (state_q)
      RUN: begin
        if (fire) begin
          buf_d[pos_q] = in_ch.in_data;
          pos_d        = (pos_q == AW'(NOut - 1)) ? '0 : pos_q + 1'b1;
          if (words_seen_q != 16'hFFFF) words_seen_d = words_seen_q + 16'd1;
          if (words_seen_q >= 16'(NOut)) wrapped_d = 1'b1;
        end
        if (prog_done) begin
          state_d   = CHECK;
          chk_idx_d = '0;
        end
      end
      CHECK: begin
        if (mismatch && (fail_index_q == FW'(NOut))) fail_index_d = FW'(chk_idx_q);
        if (chk_idx_q == AW'(NExpect - 1)) begin
          state_d   = DONE;
          success_d = (fail_index_d == FW'(NOut)) && (words_seen_q == 16'(NExpect)) && !wrapped_q;
        end else begin
          chk_idx_d = chk_idx_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Storage arrays survive reset so the table can be preloaded while reset is held.
    if (reset) begin
      state_d      = RUN;
      pos_d        = '0;
      chk_idx_d    = '0;
      words_seen_d = '0;
      wrapped_d    = 1'b0;
      fail_index_d = FW'(NOut);
      success_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    state_q      <= state_d;
    pos_q        <= pos_d;
    chk_idx_q    <= chk_idx_d;
    words_seen_q <= words_seen_d;
    wrapped_q    <= wrapped_d;
    fail_index_q <= fail_index_d;
    success_q    <= success_d;
    buf_q        <= buf_d;
    exp_q        <= exp_d;
  end

  assign words_seen = words_seen_q;
  assign wrapped    = wrapped_q;
  assign fail_index = fail_index_q;
  assign finished   = (state_q == DONE);
  assign success    = success_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed and randomized runs of the out channel checker against a word-list reference model.
module tb_out_channel_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        prog_done;
  logic        exp_we;
  logic [1:0]  exp_addr;
  logic [11:0] exp_data;
  logic [15:0] words_seen;
  logic        wrapped;
  logic [2:0]  fail_index;
  logic        finished;
  logic        success;

  out_channel_if #(.W(12)) ch ();

  out_channel_checker #(.W(12), .NOut(3), .NExpect(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_ch      (ch),
    .prog_done  (prog_done),
    .exp_we     (exp_we),
    .exp_addr   (exp_addr),
    .exp_data   (exp_data),
    .words_seen (words_seen),
    .wrapped    (wrapped),
    .fail_index (fail_index),
    .finished   (finished),
    .success    (success)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          m_count = 0;
  logic [11:0] m_buf [3];
  logic [11:0] m_exp [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_count = 0;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_success"}, success, 0);
    chk({tag, "_words"}, words_seen, 0);
    chk({tag, "_wrapped"}, wrapped, 0);
    chk({tag, "_fail_idx"}, fail_index, 3);
    chk({tag, "_in_ready"}, ch.in_ready, 1);
  endtask

  task automatic wr_exp(input logic [1:0] a, input logic [11:0] d);
    exp_we = 1'b1; exp_addr = a; exp_data = d;
    step();
    exp_we = 1'b0;
    if (a < 2'd3) m_exp[a] = d;
  endtask

  // One word handshake; optionally with prog_done and a concurrent table write.
  task automatic send(input logic [11:0] d, input bit done, input bit side_wr);
    ch.in_valid = 1'b1; ch.in_data = d; prog_done = done;
    if (side_wr) begin
      exp_we = 1'b1; exp_addr = 2'($urandom_range(0, 3)); exp_data = 12'($urandom_range(0, 3));
    end
    step();
    m_buf[m_count % 3] = d;
    m_count++;
    if (side_wr && exp_addr < 2'd3) m_exp[exp_addr] = exp_data;
    ch.in_valid = 1'b0; prog_done = 1'b0; exp_we = 1'b0;
  endtask

  task automatic done_only();
    prog_done = 1'b1;
    step();
    prog_done = 1'b0;
  endtask

  // Called right after the edge that sampled prog_done.
  task automatic finish_and_check(input string tag);
    int lat = 1;
    int fail = 3;
    int ws;
    bit wr;
    bit succ;
    chk({tag, "_not_yet"}, finished, 0);
    while (!finished && lat < 12) begin
      ch.in_valid = 1'($urandom_range(0, 1)); ch.in_data = 12'($urandom);
      exp_we = 1'b1; exp_addr = 2'($urandom_range(0, 2)); exp_data = 12'($urandom);
      chk({tag, "_rdy_check"}, ch.in_ready, 0);
      step();
      lat++;
    end
    ch.in_valid = 1'b0; exp_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_buf[k] !== m_exp[k]) begin
        fail = k;
        break;
      end
    end
    ws   = (m_count > 65535) ? 65535 : m_count;
    wr   = (m_count > 3);
    succ = (fail == 3) && (m_count == 3) && !wr;
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_success"}, success, succ);
    chk({tag, "_fail_idx"}, fail_index, fail);
    chk({tag, "_words"}, words_seen, ws);
    chk({tag, "_wrapped"}, wrapped, wr);
    ch.in_valid = 1'b1; prog_done = 1'b1;
    idle(2);
    ch.in_valid = 1'b0; prog_done = 1'b0;
    chk({tag, "_hold_fin"}, finished, 1);
    chk({tag, "_hold_succ"}, success, succ);
    chk({tag, "_hold_words"}, words_seen, ws);
    chk({tag, "_hold_rdy"}, ch.in_ready, 0);
  endtask

  initial begin
    int n;
    bit match;
    reset = 1'b1; prog_done = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    ch.in_valid = 1'b0; ch.in_data = '0;
    step();
    wr_exp(2'd0, 12'd3);
    wr_exp(2'd1, 12'd0);
    wr_exp(2'd2, 12'd1);
    wr_exp(2'd3, 12'd7);
    reset = 1'b0;
    check_idle_state("reset");

    send(12'd3, 0, 0); send(12'd0, 0, 0); send(12'd1, 0, 0);
    done_only();
    finish_and_check("case1");

    do_reset();
    send(12'd3, 0, 0); send(12'd1, 0, 0); send(12'd1, 0, 0);
    done_only();
    finish_and_check("case2");

    do_reset();
    send(12'd3, 0, 0); idle(2); send(12'd0, 0, 0);
    done_only();
    finish_and_check("case3");

    do_reset();
    send(12'd5, 0, 0); send(12'd3, 0, 0); send(12'd0, 0, 0); send(12'd1, 0, 0);
    done_only();
    finish_and_check("case4");

    do_reset();
    send(12'd3, 0, 0); send(12'd0, 0, 0); send(12'd1, 0, 0);
    done_only();
    step();
    do_reset();
    check_idle_state("midcheck_rst");
    send(12'd3, 0, 0); send(12'd0, 0, 0); send(12'd1, 0, 0);
    done_only();
    finish_and_check("case5");

    do_reset();
    send(12'd3, 0, 0); send(12'd0, 0, 0); send(12'd1, 1, 0);
    finish_and_check("case6");

    for (int r = 0; r < 25; r++) begin
      do_reset();
      if ($urandom_range(0, 1) == 1) wr_exp(2'($urandom_range(0, 3)), 12'($urandom_range(0, 3)));
      n = $urandom_range(0, 5);
      match = (n == 3) && ($urandom_range(0, 1) == 1);
      if (n == 0) begin
        done_only();
      end else begin
        for (int i = 0; i < n; i++) begin
          bit last_done;
          last_done = (i == n - 1) && ($urandom_range(0, 1) == 1);
          chk("rand_rdy_run", ch.in_ready, 1);
          send(match ? m_exp[i] : 12'($urandom_range(0, 3)), last_done,
               !match && ($urandom_range(0, 3) == 0));
          if (last_done) break;
          if (i == n - 1) done_only();
          else idle($urandom_range(0, 2));
        end
      end
      finish_and_check("random");
    end

    do_reset();
    ch.in_valid = 1'b1; ch.in_data = 12'h0AB;
    idle(65540);
    ch.in_valid = 1'b0;
    m_count = 65540;
    for (int k = 0; k < 3; k++) m_buf[k] = 12'h0AB;
    done_only();
    finish_and_check("saturate");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
